// File: rtl/e310_spi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : e310_spi_arbiter                                              |
// | Brief    : Round-robin arbiter and serializer sharing one AD9361 SPI     |
// |            bus between two radio channels. Each granted request is a     |
// |            complete 24-bit word shifted out MSB first. The last 8        |
// |            captured MISO bits return on the granted channel's response.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module e310_spi_arbiter #(
    parameter int WIDTH    = 24,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 4
) (
    input  logic             bus_clk,
    input  logic             bus_rst,
    input  logic [WIDTH-1:0] req0_tdata,
    input  logic             req0_tvalid,
    output logic             req0_tready,
    output logic [7:0]       resp0_tdata,
    output logic             resp0_tvalid,
    input  logic             resp0_tready,
    input  logic [WIDTH-1:0] req1_tdata,
    input  logic             req1_tvalid,
    output logic             req1_tready,
    output logic [7:0]       resp1_tdata,
    output logic             resp1_tvalid,
    input  logic             resp1_tready,
    output logic             spi_sen,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             busy,
    output logic             last_grant
);

    // Shared phase/delay counter must hold the largest of the four delays.
    localparam int C_CNT_MAX = (CLK_DIV > CS_SETUP ?
                                    (CLK_DIV > CS_HOLD ? (CLK_DIV > IDLE_GAP ? CLK_DIV : IDLE_GAP)
                                                       : (CS_HOLD > IDLE_GAP ? CS_HOLD : IDLE_GAP))
                                  : (CS_SETUP > CS_HOLD ? (CS_SETUP > IDLE_GAP ? CS_SETUP : IDLE_GAP)
                                                        : (CS_HOLD > IDLE_GAP ? CS_HOLD : IDLE_GAP)));
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_BIT_W   = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RESP  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_BIT_W-1:0]  r_bit_cnt;
    logic [WIDTH-1:0]    r_sr;
    logic                r_miso_q;
    logic                r_grant;

    logic                w_any_valid;
    logic                w_arb_pick;
    logic                w_sel_valid;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_phase_end;
    logic                w_last_bit;
    logic                w_setup_done;
    logic                w_hold_done;
    logic                w_gap_done;
    logic                w_resp_valid;
    logic                w_resp_ready;

    assign w_any_valid  = req0_tvalid | req1_tvalid;
    // On a tie the channel not served last time wins.
    assign w_arb_pick   = (req0_tvalid & req1_tvalid) ? ~last_grant : req1_tvalid;
    assign w_sel_valid  = r_grant ? req1_tvalid : req0_tvalid;
    assign w_sel_data   = r_grant ? req1_tdata  : req0_tdata;
    assign w_phase_end  = (r_cnt == C_CNT_W'(CLK_DIV - 1));
    assign w_last_bit   = (r_bit_cnt == C_BIT_W'(WIDTH - 1));
    assign w_setup_done = (r_cnt == C_CNT_W'(CS_SETUP - 1));
    assign w_hold_done  = (r_cnt == C_CNT_W'(CS_HOLD - 1));
    assign w_gap_done   = (r_cnt == C_CNT_W'(IDLE_GAP - 1));
    assign w_resp_valid = resp0_tvalid | resp1_tvalid;
    assign w_resp_ready = r_grant ? resp1_tready : resp0_tready;

    // State register.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_valid) w_next = ST_ARB;
            // A request withdrawn before its grant simply returns to idle.
            ST_ARB:   w_next = w_sel_valid ? ST_SETUP : ST_IDLE;
            ST_SETUP: if (w_setup_done) w_next = ST_SHIFT;
            ST_SHIFT: if (spi_sclk && w_phase_end && w_last_bit) w_next = ST_HOLD;
            ST_HOLD:  if (w_hold_done) w_next = ST_RESP;
            ST_RESP:  if (w_resp_valid && w_resp_ready) w_next = ST_GAP;
            ST_GAP:   if (w_gap_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Phase/delay counter: restarts on every state change and every SCLK half-period.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_SHIFT && w_phase_end) begin
            r_cnt <= '0;
        end else if (r_state == ST_SETUP || r_state == ST_SHIFT ||
                     r_state == ST_HOLD  || r_state == ST_GAP) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
        end
    end

    // Grant, shift register, SPI pins and response ports.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_grant      <= 1'b0;
            last_grant   <= 1'b1;
            r_sr         <= '0;
            r_miso_q     <= 1'b0;
            r_bit_cnt    <= '0;
            req0_tready  <= 1'b0;
            req1_tready  <= 1'b0;
            resp0_tdata  <= '0;
            resp1_tdata  <= '0;
            resp0_tvalid <= 1'b0;
            resp1_tvalid <= 1'b0;
            spi_sen      <= 1'b1;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            req0_tready <= 1'b0;
            req1_tready <= 1'b0;
            busy        <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    // Decide here so tready is a registered pulse in the ARB cycle.
                    if (w_any_valid) begin
                        r_grant     <= w_arb_pick;
                        req0_tready <= ~w_arb_pick;
                        req1_tready <= w_arb_pick;
                    end
                end
                ST_ARB: begin
                    if (w_sel_valid) begin
                        r_sr       <= w_sel_data;
                        spi_mosi   <= w_sel_data[WIDTH-1];
                        spi_sen    <= 1'b0;
                        last_grant <= r_grant;
                        r_bit_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_phase_end) begin
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            r_miso_q <= spi_miso;
                        end else begin
                            // Captured bit enters the LSB as data leaves the MSB.
                            spi_sclk  <= 1'b0;
                            r_sr      <= {r_sr[WIDTH-2:0], r_miso_q};
                            spi_mosi  <= w_last_bit ? 1'b0 : r_sr[WIDTH-2];
                            r_bit_cnt <= r_bit_cnt + C_BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_hold_done) begin
                        spi_sen <= 1'b1;
                        if (r_grant) begin
                            resp1_tdata <= r_sr[7:0];
                        end else begin
                            resp0_tdata <= r_sr[7:0];
                        end
                    end
                end
                ST_RESP: begin
                    if (!w_resp_valid) begin
                        resp0_tvalid <= ~r_grant;
                        resp1_tvalid <= r_grant;
                    end else if (w_resp_ready) begin
                        resp0_tvalid <= 1'b0;
                        resp1_tvalid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e310_spi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_e310_spi_arbiter                                           |
// | Brief    : Scoreboard bench for e310_spi_arbiter: default-parameter      |
// |            instance with a MISO slave model, plus a fast-clock instance. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_e310_spi_arbiter;

    localparam int C_IDLE_GAP = 4;
    localparam int C_CS_LOW   = 100;

    typedef struct {
        logic        ch;
        logic [23:0] word;
        logic [23:0] miso;
        logic [7:0]  resp;
    } tx_t;

    logic        bus_clk = 1'b0;
    logic        bus_rst;
    logic [23:0] req0_tdata, req1_tdata;
    logic        req0_tvalid, req1_tvalid, req0_tready, req1_tready;
    logic [7:0]  resp0_tdata, resp1_tdata;
    logic        resp0_tvalid, resp1_tvalid, resp0_tready, resp1_tready;
    logic        spi_sen, spi_sclk, spi_mosi, busy, last_grant;
    logic        spi_miso = 1'b0;

    logic        f_rst;
    logic [23:0] f_req0_tdata, f_req1_tdata;
    logic        f_req0_tvalid, f_req1_tvalid, f_req0_tready, f_req1_tready;
    logic [7:0]  f_resp0_tdata, f_resp1_tdata;
    logic        f_resp0_tvalid, f_resp1_tvalid;
    logic        f_spi_sen, f_spi_sclk, f_spi_mosi, f_busy, f_last_grant;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  fast_done = 0;

    tx_t exp_q[$];
    tx_t fly_q[$];
    int  grant_cyc[2];
    int  accept_cyc;
    int  r1_cnt;
    int  resp_seen;

    always #5 bus_clk = ~bus_clk;
    always @(posedge bus_clk) cyc <= cyc + 1;

    e310_spi_arbiter #(.WIDTH(24), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(4)) u_dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst),
        .req0_tdata(req0_tdata), .req0_tvalid(req0_tvalid), .req0_tready(req0_tready),
        .resp0_tdata(resp0_tdata), .resp0_tvalid(resp0_tvalid), .resp0_tready(resp0_tready),
        .req1_tdata(req1_tdata), .req1_tvalid(req1_tvalid), .req1_tready(req1_tready),
        .resp1_tdata(resp1_tdata), .resp1_tvalid(resp1_tvalid), .resp1_tready(resp1_tready),
        .spi_sen(spi_sen), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .busy(busy), .last_grant(last_grant)
    );

    e310_spi_arbiter #(.WIDTH(24), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1)) u_dut_fast (
        .bus_clk(bus_clk), .bus_rst(f_rst),
        .req0_tdata(f_req0_tdata), .req0_tvalid(f_req0_tvalid), .req0_tready(f_req0_tready),
        .resp0_tdata(f_resp0_tdata), .resp0_tvalid(f_resp0_tvalid), .resp0_tready(1'b1),
        .req1_tdata(f_req1_tdata), .req1_tvalid(f_req1_tvalid), .req1_tready(f_req1_tready),
        .resp1_tdata(f_resp1_tdata), .resp1_tvalid(f_resp1_tvalid), .resp1_tready(1'b1),
        .spi_sen(f_spi_sen), .spi_sclk(f_spi_sclk), .spi_mosi(f_spi_mosi), .spi_miso(1'b0),
        .busy(f_busy), .last_grant(f_last_grant)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_min(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            failures++;
            $display("FAIL %s: got %0d expected at least %0d", name, act, min);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout or unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic push_tx(input logic ch, input logic [23:0] w, input logic [23:0] m, input logic [7:0] r);
        tx_t t;
        t.ch = ch; t.word = w; t.miso = m; t.resp = r;
        exp_q.push_back(t);
    endtask

    // Wait for the channel's tready pulse, then optionally drop its valid after the ARB edge.
    task automatic wait_grant(input logic ch, input bit drop);
        int t = 0;
        while (t < 2000) begin
            @(negedge bus_clk);
            if (ch ? req1_tready : req0_tready) break;
            t++;
        end
        if (t >= 2000) fail_now(ch ? "grant1_timeout" : "grant0_timeout");
        @(posedge bus_clk); #1;
        if (drop) begin
            if (ch) req1_tvalid = 1'b0;
            else    req0_tvalid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 3000) begin
            @(negedge bus_clk);
            if (!busy && fly_q.size() == 0 && exp_q.size() == 0) break;
            t++;
        end
        if (t >= 3000) fail_now("idle_timeout");
        @(posedge bus_clk); #1;
    endtask

    // Monitor: grant/response scoreboard, chip-select timing and SPI slave model.
    logic        prev_sen = 1'b1, prev_sclk = 1'b0, prev_rdy_any = 1'b0;
    logic        prev_tv[2], prev_rr[2];
    logic [7:0]  prev_dt[2];
    logic [23:0] cur_miso = '0;
    logic [23:0] mosi_bits;
    int          nbits, idx, low_run, hi_run = 0;
    bit          in_low = 0, have_pulse = 0;

    always @(negedge bus_clk) begin
        logic        tv[2], rr[2];
        logic [7:0]  dt[2];
        tx_t         t;
        tv = '{resp0_tvalid, resp1_tvalid};
        rr = '{resp0_tready, resp1_tready};
        dt = '{resp0_tdata, resp1_tdata};
        if (bus_rst) begin
            fly_q.delete();
            in_low = 0; have_pulse = 0; hi_run = 0;
            prev_sen = 1'b1; prev_sclk = 1'b0; prev_rdy_any = 1'b0;
            spi_miso = 1'b0;
            prev_tv = '{1'b0, 1'b0}; prev_rr = '{1'b1, 1'b1}; prev_dt = '{8'h00, 8'h00};
        end else begin
            if (req0_tready || req1_tready) begin
                chk("grant_onehot", {31'd0, req0_tready & req1_tready}, 32'd0);
                if (exp_q.size() == 0) begin
                    fail_now("grant_unexpected");
                end else begin
                    t = exp_q.pop_front();
                    chk("grant_ch", {31'd0, req1_tready}, {31'd0, t.ch});
                    grant_cyc[req1_tready ? 1 : 0] = cyc;
                    cur_miso = t.miso;
                    fly_q.push_back(t);
                end
            end
            if (prev_sen && !spi_sen) begin
                chk("sen_after_arb", {31'd0, prev_rdy_any}, 32'd1);
                if (have_pulse) chk_min("sen_gap", hi_run, 6);
                in_low = 1; low_run = 0; idx = 0; nbits = 0; mosi_bits = '0;
                spi_miso = cur_miso[23];
            end
            if (!spi_sen) low_run++;
            if (!prev_sclk && spi_sclk) begin
                mosi_bits = {mosi_bits[22:0], spi_mosi};
                nbits++;
            end
            if (prev_sclk && !spi_sclk) begin
                idx++;
                spi_miso = (idx < 24) ? cur_miso[23 - idx] : 1'b0;
            end
            if (!prev_sen && spi_sen && in_low) begin
                chk("sen_low_len", low_run, C_CS_LOW);
                chk("mosi_nbits", nbits, 24);
                if (fly_q.size() != 0) chk("mosi_word", {8'd0, mosi_bits}, {8'd0, fly_q[0].word});
                else fail_now("mosi_no_tx");
                in_low = 0; have_pulse = 1; hi_run = 0;
            end
            if (spi_sen) hi_run++;
            if (resp1_tvalid) r1_cnt++;
            if (resp0_tvalid || resp1_tvalid) resp_seen++;
            for (int n = 0; n < 2; n++) begin
                if (tv[n] && !prev_tv[n]) chk("resp_after_sen", hi_run, 2);
                if (prev_tv[n] && !prev_rr[n]) begin
                    chk("stall_valid", {31'd0, tv[n]}, 32'd1);
                    chk("stall_data", {24'd0, dt[n]}, {24'd0, prev_dt[n]});
                end
                if (tv[n] && rr[n]) begin
                    if (fly_q.size() == 0) begin
                        fail_now("resp_unexpected");
                    end else begin
                        t = fly_q.pop_front();
                        chk("resp_ch", n, {31'd0, t.ch});
                        chk("resp_data", {24'd0, dt[n]}, {24'd0, t.resp});
                        accept_cyc = cyc;
                    end
                end
            end
            prev_tv = tv; prev_rr = rr; prev_dt = dt;
            prev_sen = spi_sen; prev_sclk = spi_sclk;
            prev_rdy_any = req0_tready | req1_tready;
        end
    end

    // Main stimulus.
    initial begin
        int t;
        bus_rst = 1'b1;
        req0_tdata = '0; req1_tdata = '0; req0_tvalid = 1'b0; req1_tvalid = 1'b0;
        resp0_tready = 1'b1; resp1_tready = 1'b1;
        repeat (3) @(posedge bus_clk); #1;
        chk("rst_sen", {31'd0, spi_sen}, 32'd1);
        chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("rst_tready", {30'd0, req0_tready, req1_tready}, 32'd0);
        chk("rst_tvalid", {30'd0, resp0_tvalid, resp1_tvalid}, 32'd0);
        chk("rst_tdata", {16'd0, resp0_tdata, resp1_tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_last_grant", {31'd0, last_grant}, 32'd1);
        bus_rst = 1'b0;

        // Single write on channel 0, MISO held low.
        r1_cnt = 0;
        push_tx(1'b0, 24'h8A5C3F, 24'h000000, 8'h00);
        req0_tdata = 24'h8A5C3F; req0_tvalid = 1'b1;
        wait_grant(1'b0, 1'b1);
        wait_idle();
        chk("t1_resp1_idle", r1_cnt, 0);

        // Readback on channel 1.
        push_tx(1'b1, 24'h012300, 24'h0000A7, 8'hA7);
        req1_tdata = 24'h012300; req1_tvalid = 1'b1;
        wait_grant(1'b1, 1'b1);
        chk("t2_last_grant", {31'd0, last_grant}, 32'd1);
        wait_idle();

        // Round-robin with both valids held from reset.
        bus_rst = 1'b1;
        repeat (2) @(posedge bus_clk); #1;
        req0_tdata = 24'hC3A501; req1_tdata = 24'h5A0F96;
        push_tx(1'b0, 24'hC3A501, 24'h0, 8'h00);
        push_tx(1'b1, 24'h5A0F96, 24'h0, 8'h00);
        push_tx(1'b0, 24'hC3A501, 24'h0, 8'h00);
        push_tx(1'b1, 24'h5A0F96, 24'h0, 8'h00);
        req0_tvalid = 1'b1; req1_tvalid = 1'b1;
        bus_rst = 1'b0;
        wait_grant(1'b0, 1'b0);
        wait_grant(1'b1, 1'b0);
        wait_grant(1'b0, 1'b0);
        wait_grant(1'b1, 1'b1);
        req0_tvalid = 1'b0;
        wait_idle();

        // Response backpressure with a pending channel 1 request.
        resp0_tready = 1'b0;
        push_tx(1'b0, 24'h3C0042, 24'h000055, 8'h55);
        req0_tdata = 24'h3C0042; req0_tvalid = 1'b1;
        wait_grant(1'b0, 1'b1);
        push_tx(1'b1, 24'h81F00F, 24'h0, 8'h00);
        req1_tdata = 24'h81F00F; req1_tvalid = 1'b1;
        t = 0;
        while (!resp0_tvalid && t < 500) begin @(posedge bus_clk); #1; t++; end
        if (t >= 500) fail_now("t4_resp_timeout");
        repeat (50) @(posedge bus_clk); #1;
        resp0_tready = 1'b1;
        wait_grant(1'b1, 1'b1);
        chk("t4_grant1_cycle", grant_cyc[1], accept_cyc + C_IDLE_GAP + 2);
        wait_idle();

        // Reset 40 cycles into a word.
        push_tx(1'b0, 24'hA5A5A5, 24'h0, 8'h00);
        req0_tdata = 24'hA5A5A5; req0_tvalid = 1'b1;
        wait_grant(1'b0, 1'b1);
        t = 0;
        while (spi_sen && t < 50) begin @(negedge bus_clk); t++; end
        if (t >= 50) fail_now("t5_sen_timeout");
        repeat (40) @(posedge bus_clk); #1;
        bus_rst = 1'b1;
        @(posedge bus_clk); #1;
        chk("t5_sen", {31'd0, spi_sen}, 32'd1);
        chk("t5_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_tvalid", {30'd0, resp0_tvalid, resp1_tvalid}, 32'd0);
        bus_rst = 1'b0;
        resp_seen = 0;
        repeat (150) @(posedge bus_clk); #1;
        chk("t5_no_resp", resp_seen, 0);
        push_tx(1'b0, 24'h123456, 24'h0000C4, 8'hC4);
        push_tx(1'b1, 24'h654321, 24'h0, 8'h00);
        req0_tdata = 24'h123456; req1_tdata = 24'h654321;
        req0_tvalid = 1'b1; req1_tvalid = 1'b1;
        wait_grant(1'b0, 1'b1);
        chk("t5_tie_last_grant", {31'd0, last_grant}, 32'd0);
        wait_grant(1'b1, 1'b1);
        wait_idle();

        t = 0;
        while (!fast_done && t < 2000) begin @(posedge bus_clk); t++; end
        if (t >= 2000) fail_now("fast_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Fast instance: CLK_DIV and all delays at their minimum.
    initial begin
        int t, low, highs, first, last, pos, adj;
        logic prev_hi;
        f_rst = 1'b1;
        f_req0_tdata = 24'hF0F00F; f_req1_tdata = '0;
        f_req0_tvalid = 1'b0; f_req1_tvalid = 1'b0;
        repeat (2) @(posedge bus_clk); #1;
        f_rst = 1'b0;
        f_req0_tvalid = 1'b1;
        t = 0;
        while (t < 100) begin @(negedge bus_clk); if (f_req0_tready) break; t++; end
        if (t >= 100) fail_now("fast_grant_timeout");
        @(posedge bus_clk); #1;
        f_req0_tvalid = 1'b0;
        t = 0;
        while (t < 100) begin @(negedge bus_clk); if (!f_spi_sen) break; t++; end
        if (t >= 100) fail_now("fast_sen_timeout");
        low = 1; highs = 0; first = -1; last = -1; pos = 0; adj = 0; prev_hi = f_spi_sclk;
        while (low < 200) begin
            @(negedge bus_clk);
            if (f_spi_sen) break;
            low++; pos++;
            if (f_spi_sclk) begin
                highs++;
                if (prev_hi) adj++;
                if (first < 0) first = pos;
                last = pos;
            end
            prev_hi = f_spi_sclk;
        end
        chk("fast_sen_low", low, 50);
        chk("fast_sclk_highs", highs, 24);
        chk("fast_sclk_span", last - first, 46);
        chk("fast_sclk_adjacent", adj, 0);
        t = 0;
        while (!f_resp0_tvalid && t < 100) begin @(negedge bus_clk); t++; end
        if (t >= 100) fail_now("fast_resp_timeout");
        chk("fast_resp", {24'd0, f_resp0_tdata}, 32'd0);
        fast_done = 1;
    end

endmodule
`default_nettype wire
